// File: rtl/jpeg_stream_ctrl.sv
// jpeg_stream_ctrl
//   Sequencer and block buffer wrapped around the jpeg_top encoder core.
//   Block-ordered RGB pixels are staged 64 at a time in a local buffer, then
//   burst gap-free into the core. Bitstream words coming back from the core
//   (which cannot be stalled) are collected into an output FIFO.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, num_blocks   image start pulse and block count (latched in IDLE)
//   s_valid/s_ready/s_pixel       upstream pixel stream {R,G,B}
//   core_enable/core_data/core_eof  registered drive into jpeg_top
//   core_bitstream/core_data_ready/core_eof_count/core_eof_partial  from jpeg_top
//   m_valid/m_ready/m_data/m_last/m_bits  output word stream
//   busy, done, blocks_sent, err_overflow  status
module jpeg_stream_ctrl #(
    parameter int OUT_FIFO_DEPTH = 128,
    parameter int BLOCK_CREDIT   = 56
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_blocks,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_pixel,
    output logic        core_enable,
    output logic [23:0] core_data,
    output logic        core_eof,
    input  logic [31:0] core_bitstream,
    input  logic        core_data_ready,
    input  logic [4:0]  core_eof_count,
    input  logic        core_eof_partial,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic [4:0]  m_bits,
    output logic        busy,
    output logic        done,
    output logic [15:0] blocks_sent,
    output logic        err_overflow
);
    localparam int AW = $clog2(OUT_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(OUT_FIFO_DEPTH);
    localparam logic [AW:0] CREDIT_C = (AW+1)'(BLOCK_CREDIT);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_BURST, S_FLUSH, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [15:0]   num_blocks_r;
    logic [5:0]    wr_idx, rd_idx;
    logic [23:0]   pix_buf [64];

    // FIFO entry layout: {last, bits[4:0], data[31:0]}
    logic [37:0]   fifo_mem [OUT_FIFO_DEPTH];
    logic [AW-1:0] fifo_wp, fifo_rp;
    logic [AW:0]   fifo_cnt;
    logic [37:0]   fifo_head;

    logic          pend_vld;
    logic [37:0]   pend_word;

    logic pix_acc, last_pix, burst_end, final_blk, capture, part_evt;
    logic credit_ok, fifo_full, pop, drain_end;
    logic push, push_ok, overflow, pend_set, pend_clr;
    logic [37:0] full_word, part_word, push_word;

    assign busy      = (state != S_IDLE);
    assign s_ready   = (state == S_FILL);
    assign pix_acc   = s_ready && s_valid;
    assign last_pix  = pix_acc && (wr_idx == 6'd63);
    assign burst_end = (state == S_BURST) && (rd_idx == 6'd63);
    assign final_blk = ((blocks_sent + 16'd1) == num_blocks_r);
    assign capture   = (state != S_IDLE);
    assign part_evt  = (state == S_FLUSH) && core_eof_partial;

    assign fifo_full = (fifo_cnt == DEPTH_C);
    assign credit_ok = ((DEPTH_C - fifo_cnt) >= CREDIT_C);
    assign fifo_head = fifo_mem[fifo_rp];
    assign m_valid   = (fifo_cnt != '0);
    assign m_data    = m_valid ? fifo_head[31:0]  : 32'd0;
    assign m_bits    = m_valid ? fifo_head[36:32] : 5'd0;
    assign m_last    = m_valid && fifo_head[37];
    assign pop       = m_valid && m_ready;
    assign drain_end = (state == S_DRAIN) && pop && fifo_head[37];

    // A zero residual count means the core has nothing partial left; emit a
    // zero marker word so downstream still sees an explicit last word.
    assign full_word = {1'b0, 5'd0, core_bitstream};
    assign part_word = {1'b1, core_eof_count,
                        (core_eof_count == 5'd0) ? 32'd0 : core_bitstream};

    // Single FIFO write port: a full word always wins; a partial that collides
    // with it is parked for one cycle so word order is preserved.
    always_comb begin
        push      = 1'b0;
        push_word = '0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        if (capture && core_data_ready) begin
            push      = 1'b1;
            push_word = full_word;
            pend_set  = part_evt;
        end else if (pend_vld) begin
            push      = 1'b1;
            push_word = pend_word;
            pend_clr  = 1'b1;
        end else if (part_evt) begin
            push      = 1'b1;
            push_word = part_word;
        end
    end

    // A pop in the same cycle frees the slot, so full+pop is not an overflow.
    assign push_ok  = push && (!fifo_full || pop);
    assign overflow = push && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && (num_blocks != 16'd0)) state_nxt = S_FILL;
            S_FILL:  if (last_pix) state_nxt = S_CHECK;
            S_CHECK: if (credit_ok) state_nxt = S_BURST;
            S_BURST: if (burst_end) state_nxt = final_blk ? S_FLUSH : S_FILL;
            S_FLUSH: if (part_evt) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx       <= '0;
            rd_idx       <= '0;
            num_blocks_r <= '0;
            blocks_sent  <= '0;
            err_overflow <= 1'b0;
            done         <= 1'b0;
            core_enable  <= 1'b0;
            core_eof     <= 1'b0;
            core_data    <= '0;
            fifo_wp      <= '0;
            fifo_rp      <= '0;
            fifo_cnt     <= '0;
            pend_vld     <= 1'b0;
        end else begin
            done <= drain_end;
            if ((state == S_IDLE) && start) begin
                if (num_blocks != 16'd0) begin
                    num_blocks_r <= num_blocks;
                    blocks_sent  <= '0;
                    err_overflow <= 1'b0;
                    wr_idx       <= '0;
                    rd_idx       <= '0;
                end else begin
                    done <= 1'b1;
                end
            end
            if (pix_acc) wr_idx <= wr_idx + 6'd1;

            // core_* are registered, so the core sees the burst one cycle
            // behind the BURST state.
            core_enable <= (state == S_BURST);
            core_eof    <= (state == S_BURST) && (rd_idx == 6'd0) && final_blk;
            if (state == S_BURST) begin
                core_data <= pix_buf[rd_idx];
                rd_idx    <= rd_idx + 6'd1;
                if (rd_idx == 6'd63) blocks_sent <= blocks_sent + 16'd1;
            end

            if (push_ok) fifo_wp <= fifo_wp + AW'(1);
            if (pop)     fifo_rp <= fifo_rp + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (overflow) err_overflow <= 1'b1;

            if (pend_set)      pend_vld <= 1'b1;
            else if (pend_clr) pend_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_acc)  pix_buf[wr_idx]   <= s_pixel;
        if (push_ok)  fifo_mem[fifo_wp] <= push_word;
        if (pend_set) pend_word         <= part_word;
    end

endmodule

// File: tb/tb_jpeg_stream_ctrl.sv
// Bench for jpeg_stream_ctrl: a table of image scenarios plus hand-written
// corner sequences and randomized images, all checked against a word-level
// model (pixel order, burst shape, expected output word list).
module tb_jpeg_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_blocks;
    logic        s_valid, s_ready;
    logic [23:0] s_pixel;
    logic        core_enable, core_eof;
    logic [23:0] core_data;
    logic [31:0] core_bitstream;
    logic        core_data_ready, core_eof_partial;
    logic [4:0]  core_eof_count;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic [4:0]  m_bits;
    logic        busy, done, err_overflow;
    logic [15:0] blocks_sent;

    jpeg_stream_ctrl #(.OUT_FIFO_DEPTH(128), .BLOCK_CREDIT(56)) dut (
        .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .core_enable(core_enable), .core_data(core_data), .core_eof(core_eof),
        .core_bitstream(core_bitstream), .core_data_ready(core_data_ready),
        .core_eof_count(core_eof_count), .core_eof_partial(core_eof_partial),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_bits(m_bits), .busy(busy), .done(done), .blocks_sent(blocks_sent),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nb; int cnt; bit same; int vpct; int rpct; bit ramp;
        int exp_bits; int exp_blocks;
    } vec_t;
    vec_t tbl [4];

    int vectors = 0;
    int miscompares = 0;

    logic [37:0] exp_q [$];
    logic [37:0] got_q [$];
    logic [24:0] core_log [$];
    logic [23:0] pix_q [$];
    int          runs [$];
    int run_len, done_cnt, pix_target, valid_pct, ready_pct, flood_req, part_cnt;
    bit pix_en, bg_en, ramp, part_req, same_req, flood_track, pix_new;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        exp_q.delete(); got_q.delete(); core_log.delete(); pix_q.delete(); runs.delete();
        run_len = 0; done_cnt = 0; pix_target = 0; flood_req = 0;
        pix_en = 0; bg_en = 0; part_req = 0; same_req = 0; pix_new = 1; ramp = 0;
        flood_track = 1;
    endtask

    task automatic issue_full(input logic [31:0] d, input bit track);
        core_data_ready = 1'b1;
        core_bitstream  = d;
        if (track) exp_q.push_back({1'b0, 5'd0, d});
    endtask

    task automatic sample();
        if (s_valid && s_ready) begin pix_q.push_back(s_pixel); pix_new = 1; end
        if (m_valid && m_ready) got_q.push_back({m_last, m_bits, m_data});
        if (core_enable) begin
            core_log.push_back({core_eof, core_data});
            run_len++;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (done) done_cnt++;
    endtask

    // One clock: drive stimulus (core model + upstream + downstream), sample
    // at the falling edge, return just after the rising edge.
    task automatic cyc();
        logic [31:0] d;
        core_data_ready = 1'b0; core_eof_partial = 1'b0; core_eof_count = 5'd0;
        if (pix_new) begin
            s_pixel = ramp ? 24'(pix_q.size()) : 24'($urandom);
            pix_new = 0;
        end
        s_valid = pix_en && (pix_q.size() < pix_target) && ($urandom_range(99) < valid_pct);
        m_ready = ($urandom_range(99) < ready_pct);
        if (part_req) begin
            d = $urandom;
            if (same_req) issue_full(d, 1'b1);
            core_bitstream   = d;
            core_eof_partial = 1'b1;
            core_eof_count   = 5'(part_cnt);
            exp_q.push_back({1'b1, 5'(part_cnt), (part_cnt == 0) ? 32'd0 : d});
            part_req = 0;
            bg_en    = 0;
        end else if (flood_req > 0) begin
            issue_full($urandom, flood_track);
            flood_req--;
        end else if (bg_en && ($urandom_range(7) == 0)) begin
            issue_full($urandom, 1'b1);
        end
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {s_ready, core_enable, core_eof, m_valid, m_last, busy, done, err_overflow}, 0);
        chk({tag, "_data"}, {core_data, m_data}, 0);
        chk({tag, "_cnt"}, {m_bits, blocks_sent}, 0);
    endtask

    task automatic wait_core(input int n);
        int k = 0;
        while (core_log.size() < n && k < 20000) begin cyc(); k++; end
        chk("wait_core_enable", core_log.size() >= n, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 20000) begin cyc(); k++; end
        chk("wait_done", done_cnt > 0, 1);
    endtask

    task automatic start_image(input int nb);
        clear_logs();
        num_blocks = 16'(nb);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic check_image(input int nb, input int exp_bits);
        int bad;
        chk("burst_len", core_log.size(), 64 * nb);
        bad = 0;
        foreach (core_log[i])
            if (i >= pix_q.size() || core_log[i][23:0] !== pix_q[i]) bad++;
        chk("core_data_order", bad, 0);
        bad = 0;
        foreach (core_log[i])
            if (core_log[i][24] !== (i == 64 * (nb - 1))) bad++;
        chk("core_eof_pos", bad, 0);
        bad = 0;
        foreach (runs[i]) if (runs[i] != 64) bad++;
        chk("burst_count", runs.size(), nb);
        chk("burst_gapfree", bad, 0);
        chk("out_words", got_q.size(), exp_q.size());
        bad = 0;
        foreach (got_q[i]) if (i >= exp_q.size() || got_q[i] !== exp_q[i]) bad++;
        chk("out_content", bad, 0);
        if (got_q.size() > 0) begin
            chk("m_last_final", got_q[$][37], 1);
            chk("m_bits_final", got_q[$][36:32], exp_bits);
        end
        chk("blocks_sent", blocks_sent, nb);
        chk("done_pulses", done_cnt, 1);
        chk("idle_after", busy, 0);
    endtask

    task automatic finish_image(input int nb, input int cnt, input bit same, input int exp_bits);
        wait_core(64 * nb);
        repeat (3) cyc();
        part_req = 1; same_req = same; part_cnt = cnt;
        cyc();
        wait_done();
        cyc();
        check_image(nb, exp_bits);
    endtask

    task automatic run_image(input vec_t v);
        start_image(v.nb);
        chk("err_cleared", err_overflow, 0);
        chk("busy_on_start", busy, 1);
        valid_pct = v.vpct; ready_pct = v.rpct; ramp = v.ramp;
        pix_target = 64 * v.nb; pix_en = 1; bg_en = 1;
        finish_image(v.nb, v.cnt, v.same, v.exp_bits);
        chk("blocks_expected", blocks_sent, v.exp_blocks);
    endtask

    initial begin
        vec_t v;
        int k;
        tbl[0] = '{nb:1, cnt:12, same:0, vpct:100, rpct:100, ramp:1, exp_bits:12, exp_blocks:1};
        tbl[1] = '{nb:3, cnt:20, same:0, vpct:50,  rpct:100, ramp:0, exp_bits:20, exp_blocks:3};
        tbl[2] = '{nb:1, cnt:5,  same:1, vpct:100, rpct:70,  ramp:0, exp_bits:5,  exp_blocks:1};
        tbl[3] = '{nb:2, cnt:0,  same:0, vpct:80,  rpct:60,  ramp:0, exp_bits:0,  exp_blocks:2};

        rst = 1'b1; start = 0; num_blocks = 0; s_valid = 0; s_pixel = 0; m_ready = 0;
        core_bitstream = 0; core_data_ready = 0; core_eof_count = 0; core_eof_partial = 0;
        clear_logs();
        valid_pct = 100; ready_pct = 100;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 4; i++) run_image(tbl[i]);

        // Credit stall: 80 words parked with m_ready low leaves only 48 free.
        start_image(1);
        ready_pct = 0; flood_track = 1; flood_req = 80;
        while (flood_req > 0) cyc();
        valid_pct = 100; pix_target = 64; pix_en = 1;
        k = 0;
        while (pix_q.size() < 64 && k < 1000) begin cyc(); k++; end
        chk("stall_pixels", pix_q.size(), 64);
        for (int i = 0; i < 100; i++) begin
            start = (i == 50);
            num_blocks = 16'd9;
            cyc();
        end
        start = 0;
        chk("check_stall_no_enable", core_log.size(), 0);
        chk("check_stall_busy", busy, 1);
        ready_pct = 100;
        finish_image(1, 0, 0, 0);

        // Overflow: 200 words into a stalled 128-entry FIFO.
        start_image(1);
        valid_pct = 100; ready_pct = 0; pix_target = 64; pix_en = 1;
        wait_core(64);
        cyc();
        flood_track = 0; flood_req = 200;
        while (flood_req > 0) cyc();
        cyc();
        chk("err_overflow_set", err_overflow, 1);
        got_q.delete();
        ready_pct = 100;
        k = 0;
        while (m_valid && k < 1000) begin cyc(); k++; end
        chk("fifo_held_words", got_q.size(), 128);
        got_q.delete(); exp_q.delete();
        part_req = 1; part_cnt = 7; same_req = 0;
        cyc();
        wait_done();
        cyc();
        check_image(1, 7);
        run_image(tbl[0]);

        // Reset in the middle of a burst, then a normal image.
        start_image(2);
        valid_pct = 100; ready_pct = 100; pix_target = 128; pix_en = 1;
        wait_core(10);
        pix_en = 0; s_valid = 0;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        cyc();
        run_image(tbl[1]);

        // Zero-block image.
        clear_logs();
        num_blocks = 16'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        chk("zero_blocks_done", done_cnt, 1);
        chk("zero_blocks_no_enable", core_log.size(), 0);
        chk("zero_blocks_idle", busy, 0);

        for (int r = 0; r < 4; r++) begin
            v.nb = $urandom_range(4, 1);
            v.cnt = $urandom_range(31, 0);
            v.same = 1'($urandom_range(1, 0));
            v.vpct = $urandom_range(100, 30);
            v.rpct = $urandom_range(100, 40);
            v.ramp = 0;
            v.exp_bits = v.cnt;
            v.exp_blocks = v.nb;
            run_image(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
